// File: rtl/qei_emitter.sv
// Quadrature encoder waveform generator with a decoder-compatible position tracker.
// A move command emits Gray-coded A/B edges at a fixed spacing until N whole counts are emitted.
//
// state | meaning
// IDLE  | waiting for a move command, cmd_ready high
// RUN   | emitting edges until remaining counts reach zero or abort
module qei_emitter #(
   parameter int BIT_WIDTH    = 8,
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_dir,
   input  logic [BIT_WIDTH-1:0]    cmd_count,
   input  logic [BIT_WIDTH-1:0]    division_ratio,
   input  logic [PERIOD_WIDTH-1:0] edge_period,
   input  logic                    abort,
   output logic                    enc_a,
   output logic                    enc_b,
   output logic [BIT_WIDTH-1:0]    position,
   output logic                    busy,
   output logic                    done
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]              r_state;
   logic                    r_dir;
   logic [BIT_WIDTH-1:0]    r_ratio;
   logic [PERIOD_WIDTH-1:0] r_period;
   logic [PERIOD_WIDTH-1:0] r_timer;
   logic [BIT_WIDTH-1:0]    r_remaining;
   logic [1:0]              r_phase;
   logic [BIT_WIDTH-1:0]    r_pre;
   logic [BIT_WIDTH-1:0]    r_pos;
   logic                    r_enc_a;
   logic                    r_enc_b;
   logic                    r_busy;
   logic                    r_ready;
   logic                    r_done;

   logic [PERIOD_WIDTH-1:0] w_period_eff;
   logic                    w_edge;
   logic                    w_count;
   logic                    w_last;
   logic [1:0]              w_next_phase;

   assign w_period_eff = (edge_period == '0) ? PERIOD_WIDTH'(1) : edge_period;
   assign w_edge       = (r_state == S_RUN) && !abort && (r_timer == PERIOD_WIDTH'(1));
   assign w_next_phase = r_dir ? (r_phase - 2'd1) : (r_phase + 2'd1);
   assign w_count      = r_dir ? (r_pre == '0) : (r_pre == r_ratio);
   assign w_last       = w_count && (r_remaining == BIT_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_dir       <= 1'b0;
         r_ratio     <= '0;
         r_period    <= PERIOD_WIDTH'(1);
         r_timer     <= '0;
         r_remaining <= '0;
         r_phase     <= 2'd0;
         r_pre       <= '0;
         r_pos       <= '0;
         r_enc_a     <= 1'b0;
         r_enc_b     <= 1'b0;
         r_busy      <= 1'b0;
         r_ready     <= 1'b1;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_dir       <= cmd_dir;
                  r_ratio     <= division_ratio;
                  r_period    <= w_period_eff;
                  r_timer     <= w_period_eff;
                  r_remaining <= cmd_count;
                  if (cmd_count == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                     r_busy  <= 1'b1;
                     r_ready <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               // abort suppresses an edge due in the same cycle
               if (abort) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
                  r_done  <= 1'b1;
               end else if (w_edge) begin
                  r_timer <= r_period;
                  r_phase <= w_next_phase;
                  r_enc_b <= w_next_phase[1];
                  r_enc_a <= w_next_phase[1] ^ w_next_phase[0];
                  if (r_dir) begin
                     r_pre <= w_count ? r_ratio : (r_pre - BIT_WIDTH'(1));
                     if (w_count) r_pos <= r_pos - BIT_WIDTH'(1);
                  end else begin
                     r_pre <= w_count ? '0 : (r_pre + BIT_WIDTH'(1));
                     if (w_count) r_pos <= r_pos + BIT_WIDTH'(1);
                  end
                  if (w_count) r_remaining <= r_remaining - BIT_WIDTH'(1);
                  if (w_last) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_ready <= 1'b1;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_timer <= r_timer - PERIOD_WIDTH'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready = r_ready;
   assign enc_a     = r_enc_a;
   assign enc_b     = r_enc_b;
   assign position  = r_pos;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
